lut_m_ctrl: RTL and testbench

Controller that owns both write paths of one memory LUT (`lut_m`). It deserializes a narrow configuration stream into a full MEM_SIZE-bit shadow word and commits it with a single `config_en` pulse. It also arbitrates fabric single-bit writes against that load, so the LUT never sees a bit write while a block load is in progress. It sits between the CLB configuration chain / fabric write logic and the `lut_m` instance, in the same clock domain.

---
 rtl/lut_m_ctrl_pkg.sv | 20 ++
 rtl/lut_m_ctrl_if.sv | 27 ++
 rtl/lut_m.sv | 28 ++
 rtl/lut_m_ctrl_cfg_deserializer.sv | 50 +++++
 rtl/lut_m_ctrl.sv | 110 +++++++++++
 tb/tb_lut_m_ctrl.sv | 243 ++++++++++++++++++++++++
 6 files changed

// File: rtl/lut_m_ctrl_pkg.sv
// Shared types and sizing helpers for the lut_m controller.
package lut_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic int unsigned num_chunks(input int unsigned mem_size,
                                               input int unsigned cfg_width);
        return mem_size / cfg_width;
    endfunction

    // A single-chunk load still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned chunks);
        return (chunks <= 1) ? 1 : $clog2(chunks);
    endfunction

endpackage

// File: rtl/lut_m_ctrl_if.sv
// Config-stream and fabric bit-write handshakes into lut_m_ctrl.
interface lut_m_ctrl_if #(
    parameter int unsigned INPUTS       = 4,
    parameter int unsigned CONFIG_WIDTH = 4
) ();

    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [CONFIG_WIDTH-1:0] cfg_data;
    logic                    cfg_abort;
    logic                    cfg_done;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [INPUTS-1:0]       wr_addr;
    logic                    wr_data;

    modport master (
        output cfg_valid, cfg_data, cfg_abort, wr_valid, wr_addr, wr_data,
        input  cfg_ready, cfg_done, wr_ready
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_abort, wr_valid, wr_addr, wr_data,
        output cfg_ready, cfg_done, wr_ready
    );

endinterface

// File: rtl/lut_m.sv
// Memory LUT: block config load or single-bit write on config_clk, async read.
module lut_m #(
    parameter int unsigned INPUTS   = 4,
    parameter int unsigned MEM_SIZE = 2**INPUTS
) (
    input  logic                config_clk,
    input  logic                config_en,
    input  logic [MEM_SIZE-1:0] config_in,
    input  logic                write_en,
    input  logic                data_in,
    input  logic [INPUTS-1:0]   waddr,
    input  logic [INPUTS-1:0]   addr,
    output logic                out
);

    logic [MEM_SIZE-1:0] mem_q;

    always_ff @(posedge config_clk) begin
        if (config_en) begin
            mem_q <= config_in;
        end else if (write_en) begin
            mem_q[waddr] <= data_in;
        end
    end

    assign out = mem_q[addr];

endmodule

// File: rtl/lut_m_ctrl_cfg_deserializer.sv
// Shadow register and chunk counter: assembles config chunks LSB-first.
module cfg_deserializer
    import lut_ctrl_pkg::*;
#(
    parameter int unsigned MEM_SIZE     = 16,
    parameter int unsigned CONFIG_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    clear_i,
    input  logic [CONFIG_WIDTH-1:0] data_i,
    output logic [MEM_SIZE-1:0]     shadow_o,
    output logic                    last_o
);

    localparam int unsigned NUM_CHUNKS = num_chunks(MEM_SIZE, CONFIG_WIDTH);
    localparam int unsigned CNT_W      = cnt_width(NUM_CHUNKS);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MEM_SIZE-1:0] shadow_q, shadow_d;
    int unsigned         base;

    assign last_o   = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
    assign shadow_o = shadow_q;

    // Counter wraps to zero on the last chunk so it never indexes past the word.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        base     = int'(cnt_q) * CONFIG_WIDTH;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            shadow_d[base +: CONFIG_WIDTH] = data_i;
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/lut_m_ctrl.sv
// Owns both lut_m write paths: chunked config load and arbitrated bit writes.
module lut_m_ctrl
    import lut_ctrl_pkg::*;
#(
    parameter int unsigned INPUTS       = 4,
    parameter int unsigned MEM_SIZE     = 2**INPUTS,
    parameter int unsigned CONFIG_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    lut_m_ctrl_if.slave         bus,
    output logic                lut_config_en,
    output logic [MEM_SIZE-1:0] lut_config_in,
    output logic                lut_write_en,
    output logic                lut_data_in,
    output logic [INPUTS-1:0]   lut_waddr,
    output logic                busy
);

    state_t            state_q, state_d;
    logic              cfg_ready, wr_ready, cfg_done;
    logic              load, clear, last;
    logic              wr_en_q, wr_en_d;
    logic              wdata_q, wdata_d;
    logic [INPUTS-1:0] waddr_q, waddr_d;

    cfg_deserializer #(
        .MEM_SIZE     (MEM_SIZE),
        .CONFIG_WIDTH (CONFIG_WIDTH)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .clear_i  (clear),
        .data_i   (bus.cfg_data),
        .shadow_o (lut_config_in),
        .last_o   (last)
    );

    // Abort wins over a same-cycle chunk in LOAD; a chunk wins over a bit write in IDLE.
    always_comb begin
        state_d       = state_q;
        cfg_ready     = 1'b0;
        wr_ready      = 1'b0;
        cfg_done      = 1'b0;
        lut_config_en = 1'b0;
        load          = 1'b0;
        clear         = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                wr_ready  = !bus.cfg_valid;
                if (bus.cfg_valid) begin
                    load    = 1'b1;
                    state_d = last ? COMMIT : LOAD;
                end
            end
            LOAD: begin
                cfg_ready = !bus.cfg_abort;
                if (bus.cfg_abort) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end else if (bus.cfg_valid) begin
                    load = 1'b1;
                    if (last) state_d = COMMIT;
                end
            end
            COMMIT: begin
                lut_config_en = 1'b1;
                cfg_done      = 1'b1;
                clear         = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d = bus.wr_valid & wr_ready;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (wr_en_d) begin
            waddr_d = bus.wr_addr;
            wdata_d = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.wr_ready  = wr_ready;
    assign bus.cfg_done  = cfg_done;
    assign lut_write_en  = wr_en_q;
    assign lut_waddr     = waddr_q;
    assign lut_data_in   = wdata_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_lut_m_ctrl.sv
// Directed bench for lut_m_ctrl driving a downstream lut_m, plus a single-chunk variant.
module tb_lut_m_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_m_ctrl_if #(.INPUTS(4), .CONFIG_WIDTH(4))  bus ();
    lut_m_ctrl_if #(.INPUTS(4), .CONFIG_WIDTH(16)) bus16 ();

    logic        cfg_en, wr_en, din, busy;
    logic [15:0] cfg_in;
    logic [3:0]  waddr;
    logic [3:0]  lut_addr;
    logic        lut_out;

    logic        cfg_en16, wr_en16, din16, busy16;
    logic [15:0] cfg_in16;
    logic [3:0]  waddr16;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    lut_m_ctrl #(.INPUTS(4), .CONFIG_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .lut_config_en (cfg_en),
        .lut_config_in (cfg_in),
        .lut_write_en  (wr_en),
        .lut_data_in   (din),
        .lut_waddr     (waddr),
        .busy          (busy)
    );

    lut_m #(.INPUTS(4)) u_lut (
        .config_clk (clk),
        .config_en  (cfg_en),
        .config_in  (cfg_in),
        .write_en   (wr_en),
        .data_in    (din),
        .waddr      (waddr),
        .addr       (lut_addr),
        .out        (lut_out)
    );

    lut_m_ctrl #(.INPUTS(4), .CONFIG_WIDTH(16)) dut16 (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus16),
        .lut_config_en (cfg_en16),
        .lut_config_in (cfg_in16),
        .lut_write_en  (wr_en16),
        .lut_data_in   (din16),
        .lut_waddr     (waddr16),
        .busy          (busy16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        #1;
        chk("send_ready", 32'(bus.cfg_ready), 1);
        chk("send_no_cfg_en", 32'(cfg_en), 0);
        tick;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_cfg_en"}, 32'(cfg_en), 0);
        chk({tag, "_done"},   32'(bus.cfg_done), 0);
        chk({tag, "_shadow"}, 32'(cfg_in), 0);
        chk({tag, "_wr_en"},  32'(wr_en), 0);
        chk({tag, "_waddr"},  32'(waddr), 0);
        chk({tag, "_din"},    32'(din), 0);
        chk({tag, "_cready"}, 32'(bus.cfg_ready), 1);
        chk({tag, "_wready"}, 32'(bus.wr_ready), 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_abort = 1'b0;
        bus.wr_valid  = 1'b0; bus.wr_addr  = '0; bus.wr_data   = 1'b0;
        bus16.cfg_valid = 1'b0; bus16.cfg_data = '0; bus16.cfg_abort = 1'b0;
        bus16.wr_valid  = 1'b0; bus16.wr_addr  = '0; bus16.wr_data   = 1'b0;
        lut_addr = '0;
        tick;
        tick;
        chk_reset_vals("rst");
        rst = 1'b0;

        // Full load 0x4321
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        bus.cfg_valid = 1'b0;
        #1;
        chk("ld_cfg_en", 32'(cfg_en), 1);
        chk("ld_done", 32'(bus.cfg_done), 1);
        chk("ld_word", 32'(cfg_in), 32'h4321);
        chk("ld_busy", 32'(busy), 1);
        chk("ld_commit_cready", 32'(bus.cfg_ready), 0);
        chk("ld_commit_wready", 32'(bus.wr_ready), 0);
        tick;
        chk("ld_cfg_en_off", 32'(cfg_en), 0);
        chk("ld_done_off", 32'(bus.cfg_done), 0);
        chk("ld_idle", 32'(busy), 0);
        lut_addr = 4'h4; #1;
        chk("lut_rd4", 32'(lut_out), 0);
        lut_addr = 4'h0; #1;
        chk("lut_rd0", 32'(lut_out), 1);

        // Bit writes
        tick;
        bus.wr_valid = 1'b1; bus.wr_addr = 4'hF; bus.wr_data = 1'b0;
        #1;
        chk("wr_ready", 32'(bus.wr_ready), 1);
        tick;
        bus.wr_valid = 1'b0;
        #1;
        chk("wr_pulse", 32'(wr_en), 1);
        chk("wr_waddr", 32'(waddr), 32'hF);
        chk("wr_din", 32'(din), 0);
        chk("wr_no_cfg", 32'(cfg_en), 0);
        tick;
        chk("wr_pulse_off", 32'(wr_en), 0);
        chk("wr_waddr_hold", 32'(waddr), 32'hF);
        lut_addr = 4'hF; #1;
        chk("lut_rdF", 32'(lut_out), 0);
        chk("wr_shadow_kept", 32'(cfg_in), 32'h4321);
        bus.wr_valid = 1'b1; bus.wr_addr = 4'h4; bus.wr_data = 1'b1;
        tick;
        bus.wr_valid = 1'b0;
        #1;
        chk("wr2_din", 32'(din), 1);
        tick;
        lut_addr = 4'h4; #1;
        chk("lut_rd4_new", 32'(lut_out), 1);
        chk("wr2_shadow_kept", 32'(cfg_in), 32'h4321);

        // Chunk beats simultaneous bit write; write waits until after COMMIT
        bus.cfg_valid = 1'b1; bus.cfg_data = 4'h5;
        bus.wr_valid  = 1'b1; bus.wr_addr  = 4'h2; bus.wr_data = 1'b0;
        #1;
        chk("arb_wready", 32'(bus.wr_ready), 0);
        chk("arb_cready", 32'(bus.cfg_ready), 1);
        tick;
        for (int d = 6; d <= 8; d++) begin
            bus.cfg_data = 4'(d);
            #1;
            chk("arb_load_wready", 32'(bus.wr_ready), 0);
            tick;
        end
        bus.cfg_valid = 1'b0;
        #1;
        chk("arb_commit_cfg_en", 32'(cfg_en), 1);
        chk("arb_commit_wready", 32'(bus.wr_ready), 0);
        chk("arb_commit_wr_en", 32'(wr_en), 0);
        tick;
        chk("arb_idle_wready", 32'(bus.wr_ready), 1);
        chk("arb_idle_cfg_en", 32'(cfg_en), 0);
        tick;
        bus.wr_valid = 1'b0;
        #1;
        chk("arb_wr_pulse", 32'(wr_en), 1);
        chk("arb_wr_waddr", 32'(waddr), 32'h2);
        chk("arb_word", 32'(cfg_in), 32'h8765);
        tick;
        lut_addr = 4'h2; #1;
        chk("arb_lut_rd2", 32'(lut_out), 0);
        lut_addr = 4'h0; #1;
        chk("arb_lut_rd0", 32'(lut_out), 1);

        // Abort after two chunks, with a chunk offered in the same cycle
        tick;
        send(4'h9); send(4'hA);
        bus.cfg_valid = 1'b1; bus.cfg_data = 4'hB; bus.cfg_abort = 1'b1;
        #1;
        chk("abt_cready", 32'(bus.cfg_ready), 0);
        chk("abt_busy", 32'(busy), 1);
        tick;
        bus.cfg_valid = 1'b0; bus.cfg_abort = 1'b0;
        #1;
        chk("abt_idle", 32'(busy), 0);
        chk("abt_no_cfg_en", 32'(cfg_en), 0);
        chk("abt_cready_back", 32'(bus.cfg_ready), 1);
        chk("abt_shadow", 32'(cfg_in), 32'h87A9);
        send(4'hC); send(4'h0); send(4'hF); send(4'h3);
        bus.cfg_valid = 1'b0;
        #1;
        chk("abt_reload_cfg_en", 32'(cfg_en), 1);
        chk("abt_reload_word", 32'(cfg_in), 32'h3F0C);
        tick;

        // Reset during the third chunk
        send(4'h1); send(4'h2);
        bus.cfg_valid = 1'b1; bus.cfg_data = 4'h3; rst = 1'b1;
        tick;
        rst = 1'b0; bus.cfg_valid = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        tick;
        chk("mid_rst_no_cfg_en", 32'(cfg_en), 0);
        send(4'hA); send(4'hB); send(4'hC); send(4'hD);
        bus.cfg_valid = 1'b0;
        #1;
        chk("rst_reload_cfg_en", 32'(cfg_en), 1);
        chk("rst_reload_word", 32'(cfg_in), 32'hDCBA);
        tick;

        // Single-chunk configuration
        bus16.cfg_valid = 1'b1; bus16.cfg_data = 16'hBEEF;
        #1;
        chk("w16_cready", 32'(bus16.cfg_ready), 1);
        chk("w16_busy0", 32'(busy16), 0);
        tick;
        bus16.cfg_valid = 1'b0;
        #1;
        chk("w16_cfg_en", 32'(cfg_en16), 1);
        chk("w16_done", 32'(bus16.cfg_done), 1);
        chk("w16_word", 32'(cfg_in16), 32'hBEEF);
        chk("w16_busy1", 32'(busy16), 1);
        tick;
        chk("w16_cfg_en_off", 32'(cfg_en16), 0);
        chk("w16_idle", 32'(busy16), 0);
        chk("w16_cready_back", 32'(bus16.cfg_ready), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
